// File: rtl/data_memory_responder.sv
// ---------------------------------------------------------------------------
// data_memory_responder
//
// Responder end of the memory-FU request interface. Word loads and stores
// go to an internal synchronous RAM. I_OUTPUT requests drive a byte output
// stream. Load results come back as CDB packets {rsv_id, data} through a
// small in-order response FIFO that has valid/ready backpressure.
//
// Optional feature macro: DMEM_BOUNDS_CHECK_EN
//   defined   : LOAD/STORE with nonzero address bits above ADDR_W are out of
//               range. The store is dropped. The load returns 0. addr_err
//               is set and stays set until reset.
//   undefined : upper address bits are ignored (aliasing), addr_err = 0.
//
// Parameters
//   ADDR_W      word-address bits, RAM depth = 2**ADDR_W words
//   RESP_DEPTH  response FIFO entries (power of two, >= 2)
//
// Ports
//   clk, nrst                  clock, synchronous active-low reset
//   i_valid/i_ready            request handshake (i_ready is independent
//                              of i_valid)
//   i_opcode/i_rsv_id          request opcode and reservation id
//   i_address/i_data           word address, store/output data
//   o_cdb/o_cdb_valid/ready    load result to the CDB arbiter
//   out_valid/out_data/ready   byte output stream
//   addr_err                   sticky out-of-range flag
// ---------------------------------------------------------------------------

package fcpu_pkg;
    localparam int DATA_W   = 32;
    localparam int RSV_ID_W = 4;
    localparam int INSTR_W  = 6;
    localparam int CDB_W    = RSV_ID_W + DATA_W;

    typedef logic [INSTR_W-1:0] opcode_t;

    localparam opcode_t I_NOP     = 6'h00;
    localparam opcode_t I_ADD     = 6'h01;
    localparam opcode_t I_SUB     = 6'h02;
    localparam opcode_t I_LOAD    = 6'h10;
    localparam opcode_t I_LOADB   = 6'h11;
    localparam opcode_t I_LOADR   = 6'h12;
    localparam opcode_t I_LOADT   = 6'h13;
    localparam opcode_t I_LOADTB  = 6'h14;
    localparam opcode_t I_STORE   = 6'h18;
    localparam opcode_t I_STOREB  = 6'h19;
    localparam opcode_t I_STORER  = 6'h1A;
    localparam opcode_t I_STORET  = 6'h1B;
    localparam opcode_t I_STORETB = 6'h1C;
    localparam opcode_t I_OUTPUT  = 6'h20;
    localparam opcode_t I_HALT    = 6'h3F;

    typedef struct packed {
        logic [RSV_ID_W-1:0] rsv_id;
        logic [DATA_W-1:0]   data;
    } cdb_t;
endpackage

module data_memory_responder
    import fcpu_pkg::*;
#(
    parameter int ADDR_W     = 10,
    parameter int RESP_DEPTH = 2
) (
    input  logic                clk,
    input  logic                nrst,
    input  logic                i_valid,
    input  logic [INSTR_W-1:0]  i_opcode,
    input  logic [RSV_ID_W-1:0] i_rsv_id,
    input  logic [DATA_W-1:0]   i_address,
    input  logic [DATA_W-1:0]   i_data,
    output logic                i_ready,
    output logic [CDB_W-1:0]    o_cdb,
    output logic                o_cdb_valid,
    input  logic                o_cdb_ready,
    output logic                out_valid,
    output logic [7:0]          out_data,
    input  logic                out_ready,
    output logic                addr_err
);

    localparam int PTR_W = $clog2(RESP_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // ------------------------------------------------------------------
    // Opcode classification
    // ------------------------------------------------------------------
    logic is_load, is_store, is_output;

    always_comb begin
        is_load   = 1'b0;
        is_store  = 1'b0;
        is_output = 1'b0;
        case (i_opcode)
            I_LOAD, I_LOADB, I_LOADR, I_LOADT, I_LOADTB:      is_load   = 1'b1;
            I_STORE, I_STOREB, I_STORER, I_STORET, I_STORETB: is_store  = 1'b1;
            I_OUTPUT:                                         is_output = 1'b1;
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Response FIFO state (declared early for the load credit)
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] fifo_count;
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    cdb_t             fifo_mem [RESP_DEPTH];
    logic             inflight;
    logic             pop, push;

    assign o_cdb_valid = (fifo_count != '0);
    assign pop         = o_cdb_valid & o_cdb_ready;
    assign push        = inflight;

    // A load is accepted only if its result is guaranteed a FIFO slot.
    // Count the results already queued, plus the one in flight, minus the
    // one leaving this cycle.
    logic [CNT_W:0] ld_pending;
    logic           ld_credit;

    assign ld_pending = {1'b0, fifo_count} + (CNT_W+1)'(inflight) - (CNT_W+1)'(pop);
    assign ld_credit  = ld_pending < (CNT_W+1)'(RESP_DEPTH);

    always_comb begin
        i_ready = 1'b1;
        if (is_load)
            i_ready = ld_credit;
        else if (is_output)
            i_ready = !out_valid || out_ready;
    end

    logic accept, ld_acc, st_acc, out_acc;

    assign accept  = i_valid & i_ready;
    assign ld_acc  = accept & is_load;
    assign st_acc  = accept & is_store;
    assign out_acc = accept & is_output;

    // ------------------------------------------------------------------
    // Address range check
    // ------------------------------------------------------------------
    logic oob;

`ifdef DMEM_BOUNDS_CHECK_EN
    assign oob = |i_address[DATA_W-1:ADDR_W];

    always_ff @(posedge clk) begin
        if (!nrst)
            addr_err <= 1'b0;
        else if ((ld_acc || st_acc) && oob)
            addr_err <= 1'b1;
    end
`else
    logic unused_addr_hi;

    assign oob            = 1'b0;
    assign addr_err       = 1'b0;
    assign unused_addr_hi = ^i_address[DATA_W-1:ADDR_W];
`endif

    // ------------------------------------------------------------------
    // Data RAM. Not reset. A store and a load are never accepted in the
    // same cycle, so read-during-write ordering is not a concern.
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] ram [2**ADDR_W];
    logic [ADDR_W-1:0] ram_idx;
    logic [DATA_W-1:0] rd_data;

    assign ram_idx = i_address[ADDR_W-1:0];

    always_ff @(posedge clk) begin
        if (st_acc && !oob)
            ram[ram_idx] <= i_data;
        if (ld_acc)
            rd_data <= ram[ram_idx];
    end

    // ------------------------------------------------------------------
    // Load stage: tag and range flag ride alongside the RAM read
    // ------------------------------------------------------------------
    logic [RSV_ID_W-1:0] ld_rsv;
    logic                ld_oob;

    always_ff @(posedge clk) begin
        if (!nrst) begin
            inflight <= 1'b0;
            ld_rsv   <= '0;
            ld_oob   <= 1'b0;
        end else begin
            inflight <= ld_acc;
            if (ld_acc) begin
                ld_rsv <= i_rsv_id;
                ld_oob <= oob;
            end
        end
    end

    cdb_t push_entry;

    always_comb begin
        push_entry.rsv_id = ld_rsv;
        push_entry.data   = ld_oob ? '0 : rd_data;
    end

    // ------------------------------------------------------------------
    // Response FIFO. Pointers wrap naturally (power-of-two depth). The
    // count alone decides full or empty.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (push)
            fifo_mem[wr_ptr] <= push_entry;
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // The head is forced to zero while empty, so that stale entries never
    // show up on the bus (including right after reset).
    assign o_cdb = o_cdb_valid ? fifo_mem[rd_ptr] : '0;

    // ------------------------------------------------------------------
    // Byte output stream
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!nrst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (out_acc) begin
            out_valid <= 1'b1;
            out_data  <= i_data[7:0];
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_data_memory_responder.sv
// ---------------------------------------------------------------------------
// Directed testbench for data_memory_responder (default parameters).
// ---------------------------------------------------------------------------
module tb_data_memory_responder;
    import fcpu_pkg::*;

    logic                clk = 1'b0;
    logic                nrst;
    logic                i_valid;
    logic [INSTR_W-1:0]  i_opcode;
    logic [RSV_ID_W-1:0] i_rsv_id;
    logic [DATA_W-1:0]   i_address;
    logic [DATA_W-1:0]   i_data;
    logic                i_ready;
    logic [CDB_W-1:0]    o_cdb;
    logic                o_cdb_valid;
    logic                o_cdb_ready;
    logic                out_valid;
    logic [7:0]          out_data;
    logic                out_ready;
    logic                addr_err;

    int tests = 0;
    int fails = 0;

    data_memory_responder #(.ADDR_W(10), .RESP_DEPTH(2)) dut (
        .clk         (clk),
        .nrst        (nrst),
        .i_valid     (i_valid),
        .i_opcode    (i_opcode),
        .i_rsv_id    (i_rsv_id),
        .i_address   (i_address),
        .i_data      (i_data),
        .i_ready     (i_ready),
        .o_cdb       (o_cdb),
        .o_cdb_valid (o_cdb_valid),
        .o_cdb_ready (o_cdb_ready),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_ready   (out_ready),
        .addr_err    (addr_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input opcode_t op, input int rsv,
                         input logic [31:0] addr, input logic [31:0] data);
        i_valid   = v;
        i_opcode  = op;
        i_rsv_id  = rsv[3:0];
        i_address = addr;
        i_data    = data;
        #1;
    endtask

    task automatic idle();
        drive(1'b0, I_NOP, 0, 32'h0, 32'h0);
    endtask

    function automatic logic [63:0] cdb(input int rsv, input logic [31:0] data);
        logic [3:0] r;
        r = rsv[3:0];
        return {28'h0, r, data};
    endfunction

    logic [31:0] exp_a, exp_b;
    logic        exp_err;

    initial begin
        nrst        = 1'b0;
        o_cdb_ready = 1'b1;
        out_ready   = 1'b1;
        idle();
        repeat (2) tick();

        // Reset state
        drive(1'b0, I_LOAD, 0, 32'h0, 32'h0);
        chk("rst_cdb_valid", o_cdb_valid, 0);
        chk("rst_cdb",       o_cdb,       0);
        chk("rst_out_valid", out_valid,   0);
        chk("rst_out_data",  out_data,    0);
        chk("rst_addr_err",  addr_err,    0);
        chk("rst_ld_ready",  i_ready,     1);
        nrst = 1'b1;
        tick();

        // Store then load, latency 2 after load acceptance
        drive(1'b1, I_STORE, 0, 32'd5, 32'h12345678);
        chk("st_ready", i_ready, 1);
        tick();
        drive(1'b1, I_LOAD, 3, 32'd5, 32'h0);
        chk("ld_ready", i_ready, 1);
        tick();
        idle();
        chk("lat_t1_valid", o_cdb_valid, 0);
        tick();
        chk("lat_t2_valid", o_cdb_valid, 1);
        chk("lat_t2_cdb",   o_cdb,       cdb(3, 32'h12345678));
        tick();
        chk("pop_empty", o_cdb_valid, 0);

        // Preload and back-to-back loads
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, I_STORE, 0, i, 32'hA0 + i);
            tick();
        end
        for (int i = 0; i < 6; i++) begin
            if (i < 4) begin
                drive(1'b1, I_LOAD, i + 1, i, 32'h0);
                chk("b2b_ready", i_ready, 1);
            end else begin
                idle();
            end
            if (i >= 2) begin
                chk("b2b_valid", o_cdb_valid, 1);
                chk("b2b_cdb",   o_cdb,       cdb(i - 1, 32'hA0 + i - 2));
            end
            tick();
        end
        chk("b2b_drain", o_cdb_valid, 0);

        // Backpressure: credit limit and stable head
        o_cdb_ready = 1'b0;
        drive(1'b1, I_LOAD, 5, 32'd0, 32'h0);
        chk("bp_ready0", i_ready, 1);
        tick();
        drive(1'b1, I_LOAD, 6, 32'd1, 32'h0);
        chk("bp_ready1", i_ready, 1);
        tick();
        drive(1'b1, I_LOAD, 7, 32'd2, 32'h0);
        chk("bp_ready2_blocked", i_ready,     0);
        chk("bp_head_valid",     o_cdb_valid, 1);
        chk("bp_head_a",         o_cdb,       cdb(5, 32'hA0));
        tick();
        chk("bp_ready3_blocked", i_ready, 0);
        chk("bp_head_stable",    o_cdb,   cdb(5, 32'hA0));
        o_cdb_ready = 1'b1;
        #1;
        chk("bp_ready_on_pop", i_ready, 1);
        tick();
        idle();
        chk("bp_head_b", o_cdb, cdb(6, 32'hA1));
        tick();
        chk("bp_head_c_valid", o_cdb_valid, 1);
        chk("bp_head_c",       o_cdb,       cdb(7, 32'hA2));
        tick();
        chk("bp_drain", o_cdb_valid, 0);

        // Output stream stall
        out_ready = 1'b0;
        drive(1'b1, I_OUTPUT, 0, 32'h0, 32'h141);
        chk("out_ready0", i_ready,   1);
        chk("out_idle",   out_valid, 0);
        tick();
        chk("out_valid1", out_valid, 1);
        chk("out_data1",  out_data,  8'h41);
        drive(1'b1, I_OUTPUT, 0, 32'h0, 32'h42);
        chk("out_second_blocked", i_ready, 0);
        drive(1'b1, I_STORE, 0, 32'd9, 32'h99);
        chk("out_store_in_stall", i_ready, 1);
        tick();
        drive(1'b1, I_OUTPUT, 0, 32'h0, 32'h42);
        chk("out_still_blocked", i_ready,  0);
        chk("out_data_hold",     out_data, 8'h41);
        out_ready = 1'b1;
        #1;
        chk("out_ready_on_drain", i_ready, 1);
        tick();
        idle();
        chk("out_valid2", out_valid, 1);
        chk("out_data2",  out_data,  8'h42);
        tick();
        chk("out_cleared", out_valid, 0);

        // Reset with loads in flight
        o_cdb_ready = 1'b0;
        drive(1'b1, I_LOAD, 8, 32'd9, 32'h0);
        tick();
        drive(1'b1, I_LOAD, 9, 32'd0, 32'h0);
        chk("mr_ready", i_ready, 1);
        tick();
        idle();
        chk("mr_pre_valid", o_cdb_valid, 1);
        nrst = 1'b0;
        tick();
        nrst = 1'b1;
        drive(1'b0, I_LOAD, 0, 32'h0, 32'h0);
        chk("mr_post_valid", o_cdb_valid, 0);
        chk("mr_post_cdb",   o_cdb,       0);
        chk("mr_post_ready", i_ready,     1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("mr_no_ghost", o_cdb_valid, 0);
        end
        o_cdb_ready = 1'b1;
        drive(1'b1, I_LOAD, 10, 32'd9, 32'h0);
        tick();
        idle();
        tick();
        chk("mr_ram_kept_valid", o_cdb_valid, 1);
        chk("mr_ram_kept",       o_cdb,       cdb(10, 32'h99));
        tick();

        // Unknown opcode is accepted and produces nothing
        drive(1'b1, I_ADD, 11, 32'h0, 32'h0);
        chk("other_ready", i_ready, 1);
        tick();
        idle();
        tick();
        tick();
        chk("other_no_resp", o_cdb_valid, 0);

        // Out-of-range address
`ifdef DMEM_BOUNDS_CHECK_EN
        exp_a   = 32'h0;
        exp_b   = 32'hA0;
        exp_err = 1'b1;
`else
        exp_a   = 32'h7;
        exp_b   = 32'h7;
        exp_err = 1'b0;
`endif
        drive(1'b1, I_STORE, 0, 32'h400, 32'h7);
        tick();
        chk("oob_err_set", addr_err, exp_err);
        drive(1'b1, I_LOAD, 2, 32'h400, 32'h0);
        tick();
        drive(1'b1, I_LOAD, 3, 32'h0, 32'h0);
        tick();
        idle();
        chk("oob_load_cdb", o_cdb, cdb(2, exp_a));
        tick();
        chk("oob_ram0_cdb", o_cdb,    cdb(3, exp_b));
        chk("oob_err_hold", addr_err, exp_err);
        tick();
        nrst = 1'b0;
        tick();
        nrst = 1'b1;
        chk("oob_err_reset", addr_err, 0);
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
